// File: rtl/sbox_keying_controller.sv
// ============================================================================
// Module  : sbox_keying_controller
// Brief   : Sequences chaos warm-up, S-box generation and S-box -> table copy.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sbox_keying_controller #(
    parameter int unsigned WARMUP_ITERS   = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_W          = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       chaos_step,
    input  logic       chaos_valid,
    output logic       gen_reset,
    output logic       gen_enable_bar,
    input  logic       gen_ready,
    output logic [7:0] sbox_rd_addr,
    input  logic [7:0] sbox_rd_data,
    output logic       tbl_we,
    output logic [7:0] tbl_addr,
    output logic [7:0] tbl_wdata,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WARM_STEP = 3'd1,
        S_WARM_WAIT = 3'd2,
        S_GEN_RST   = 3'd3,
        S_GENERATE  = 3'd4,
        S_COPY      = 3'd5,
        S_DONE      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] WARM_LAST    = CNT_W'(WARMUP_ITERS);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] COPY_LAST    = CNT_W'(256);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Outputs are assigned on the transition into the state they belong to,
    // so every output is a flop that reflects the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            chaos_step     <= 1'b0;
            gen_reset      <= 1'b1;
            gen_enable_bar <= 1'b1;
            sbox_rd_addr   <= 8'd0;
            tbl_we         <= 1'b0;
            tbl_addr       <= 8'd0;
            tbl_wdata      <= 8'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            tbl_we <= 1'b0;
            done   <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                state          <= S_IDLE;
                chaos_step     <= 1'b0;
                gen_reset      <= 1'b1;
                gen_enable_bar <= 1'b1;
                busy           <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state       <= S_WARM_STEP;
                            timeout_err <= 1'b0;
                            cnt         <= '0;
                            chaos_step  <= 1'b1;
                            gen_reset   <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                    S_WARM_STEP: begin
                        state      <= S_WARM_WAIT;
                        chaos_step <= 1'b0;
                    end
                    S_WARM_WAIT: begin
                        if (chaos_valid) begin
                            if ((cnt + CNT_ONE) == WARM_LAST) begin
                                state     <= S_GEN_RST;
                                cnt       <= '0;
                                gen_reset <= 1'b1;
                            end else begin
                                state      <= S_WARM_STEP;
                                cnt        <= cnt + CNT_ONE;
                                chaos_step <= 1'b1;
                            end
                        end
                    end
                    S_GEN_RST: begin
                        state          <= S_GENERATE;
                        cnt            <= '0;
                        gen_reset      <= 1'b0;
                        gen_enable_bar <= 1'b0;
                        chaos_step     <= 1'b1;
                    end
                    S_GENERATE: begin
                        // ready is checked first so it wins over a same-cycle timeout
                        if (gen_ready) begin
                            state        <= S_COPY;
                            cnt          <= '0;
                            chaos_step   <= 1'b0;
                            sbox_rd_addr <= 8'd0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            state          <= S_ERROR;
                            timeout_err    <= 1'b1;
                            gen_enable_bar <= 1'b1;
                            gen_reset      <= 1'b1;
                            chaos_step     <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_COPY: begin
                        // Each cycle writes the byte addressed in the previous one;
                        // the read address parks at 255 for the final write.
                        if (cnt != COPY_LAST) begin
                            tbl_we    <= 1'b1;
                            tbl_addr  <= sbox_rd_addr;
                            tbl_wdata <= sbox_rd_data;
                            cnt       <= cnt + CNT_ONE;
                            if (sbox_rd_addr != 8'hFF) begin
                                sbox_rd_addr <= sbox_rd_addr + 8'd1;
                            end
                        end else begin
                            state          <= S_DONE;
                            done           <= 1'b1;
                            gen_enable_bar <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state     <= S_IDLE;
                        gen_reset <= 1'b1;
                        busy      <= 1'b0;
                    end
                    S_ERROR: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sbox_keying_controller.sv
// ============================================================================
// Module  : tb_sbox_keying_controller
// Brief   : Directed bench with oscillator/generator responders and a write scoreboard.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sbox_keying_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       chaos_step;
    logic       chaos_valid;
    logic       gen_reset;
    logic       gen_enable_bar;
    logic       gen_ready = 1'b0;
    logic [7:0] sbox_rd_addr;
    logic [7:0] sbox_rd_data;
    logic       tbl_we;
    logic [7:0] tbl_addr;
    logic [7:0] tbl_wdata;
    logic       busy;
    logic       done;
    logic       timeout_err;

    logic osc_valid = 1'b0;
    logic spurious_valid = 1'b0;
    int   ready_after = 0;

    int total = 0;
    int bad = 0;
    int warm_steps = 0;
    int gen_low = 0;
    int done_cnt = 0;
    int writes = 0;
    logic [15:0] sb_q[$];

    assign chaos_valid  = osc_valid | spurious_valid;
    assign sbox_rd_data = sbox_rd_addr ^ 8'hA5;

    always #5 clk = ~clk;

    sbox_keying_controller #(
        .WARMUP_ITERS  (4),
        .TIMEOUT_CYCLES(32),
        .CNT_W         (17)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .chaos_step    (chaos_step),
        .chaos_valid   (chaos_valid),
        .gen_reset     (gen_reset),
        .gen_enable_bar(gen_enable_bar),
        .gen_ready     (gen_ready),
        .sbox_rd_addr  (sbox_rd_addr),
        .sbox_rd_data  (sbox_rd_data),
        .tbl_we        (tbl_we),
        .tbl_addr      (tbl_addr),
        .tbl_wdata     (tbl_wdata),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Oscillator answers 3 cycles after a warm-up step; generator becomes
    // ready after ready_after enabled cycles (0 = never).
    initial begin
        int delay = 0;
        int gen_cycles = 0;
        forever begin
            @(negedge clk);
            osc_valid = 1'b0;
            if (delay > 0) begin
                delay--;
                if (delay == 0) osc_valid = 1'b1;
            end
            if (chaos_step && gen_enable_bar) delay = 3;
            if (gen_reset) begin
                gen_cycles = 0;
                gen_ready  = 1'b0;
            end else if (!gen_enable_bar) begin
                gen_cycles++;
                gen_ready = (ready_after > 0) && (gen_cycles >= ready_after);
            end
        end
    end

    // Output monitor and table-write scoreboard.
    initial begin
        logic [15:0] exp;
        forever begin
            @(negedge clk);
            if (chaos_step && gen_enable_bar) warm_steps++;
            if (!gen_enable_bar) gen_low++;
            if (done) done_cnt++;
            if (tbl_we) begin
                writes++;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
                check("tbl_addr", {24'd0, tbl_addr}, {24'd0, exp[15:8]});
                check("tbl_wdata", {24'd0, tbl_wdata}, {24'd0, exp[7:0]});
            end
        end
    end

    task automatic push_run();
        for (int i = 0; i < 256; i++) begin
            sb_q.push_back({8'(i), 8'(i) ^ 8'hA5});
        end
    endtask

    task automatic clear_counts();
        warm_steps = 0;
        gen_low    = 0;
        done_cnt   = 0;
        writes     = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_write(input logic [7:0] addr, input string tag);
        int n = 0;
        while (!(tbl_we === 1'b1 && tbl_addr === addr) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {23'd0, tbl_we, tbl_addr}, {23'd0, 1'b1, addr});
    endtask

    initial begin
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_gen_reset", {31'd0, gen_reset}, 32'd1);
        check("rst_gen_en_bar", {31'd0, gen_enable_bar}, 32'd1);
        check("rst_outs", {28'd0, chaos_step, tbl_we, done, timeout_err}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full run: 4 warm-up steps, ready after 10 cycles, 256 writes
        ready_after = 10;
        clear_counts();
        push_run();
        pulse_start();
        wait_idle("t1_idle");
        check("t1_warm_steps", warm_steps, 32'd4);
        check("t1_writes", writes, 32'd256);
        check("t1_done", done_cnt, 32'd1);
        check("t1_gen_low", gen_low, 32'd267);
        check("t1_sb_left", sb_q.size(), 32'd0);
        check("t1_timeout", {31'd0, timeout_err}, 32'd0);

        // Timeout: generator never ready
        ready_after = 0;
        clear_counts();
        pulse_start();
        wait_idle("t2_idle");
        check("t2_timeout", {31'd0, timeout_err}, 32'd1);
        check("t2_gen_low", gen_low, 32'd32);
        check("t2_writes", writes, 32'd0);
        check("t2_done", done_cnt, 32'd0);

        // Ready on the timeout cycle; the new start clears the sticky error
        ready_after = 32;
        clear_counts();
        push_run();
        pulse_start();
        check("t6_err_cleared", {31'd0, timeout_err}, 32'd0);
        wait_idle("t6_idle");
        check("t6_timeout", {31'd0, timeout_err}, 32'd0);
        check("t6_writes", writes, 32'd256);
        check("t6_done", done_cnt, 32'd1);
        check("t6_gen_low", gen_low, 32'd289);

        // Abort during copy at address 100, then a fresh full run
        ready_after = 10;
        clear_counts();
        push_run();
        pulse_start();
        wait_write(8'd100, "t3_reach100");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t3_we_after_abort", {31'd0, tbl_we}, 32'd0);
        check("t3_busy_after_abort", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("t3_writes", writes, 32'd101);
        check("t3_done", done_cnt, 32'd0);
        sb_q.delete();
        clear_counts();
        push_run();
        pulse_start();
        wait_idle("t3b_idle");
        check("t3b_writes", writes, 32'd256);
        check("t3b_done", done_cnt, 32'd1);

        // Start while busy and spurious chaos_valid outside warm-up
        clear_counts();
        push_run();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            start = (i % 2 == 0);
            @(negedge clk);
        end
        start = 1'b0;
        n = 0;
        while (gen_enable_bar !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t4_reach_gen", {31'd0, gen_enable_bar}, 32'd0);
        spurious_valid = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        spurious_valid = 1'b0;
        start = 1'b0;
        wait_idle("t4_idle");
        spurious_valid = 1'b1;
        repeat (3) @(negedge clk);
        spurious_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_warm_steps", warm_steps, 32'd4);
        check("t4_done", done_cnt, 32'd1);
        check("t4_writes", writes, 32'd256);
        check("t4_no_requeue", {31'd0, busy}, 32'd0);

        // Async reset in WARM_WAIT, checked before any clock edge
        clear_counts();
        pulse_start();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5a_busy", {31'd0, busy}, 32'd0);
        check("t5a_gen_reset", {31'd0, gen_reset}, 32'd1);
        check("t5a_gen_en_bar", {31'd0, gen_enable_bar}, 32'd1);
        check("t5a_step", {31'd0, chaos_step}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // Async reset in COPY
        clear_counts();
        push_run();
        pulse_start();
        wait_write(8'd50, "t5b_reach50");
        #2 reset = 1'b1;
        #1;
        check("t5b_we", {31'd0, tbl_we}, 32'd0);
        check("t5b_busy", {31'd0, busy}, 32'd0);
        check("t5b_gen_reset", {31'd0, gen_reset}, 32'd1);
        check("t5b_gen_en_bar", {31'd0, gen_enable_bar}, 32'd1);
        check("t5b_rd_addr", {24'd0, sbox_rd_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t5b_writes", writes, 32'd51);
        check("t5b_done", done_cnt, 32'd0);
        sb_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
